// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: shared CP0 register indices, {rd,sel} selectors, write masks,
// field layouts, ExcCodes and reset values.
package cp0_regfile_pkg;

    typedef enum logic [3:0] {
        CP_BADVADDR,
        CP_COUNT,
        CP_COMPARE,
        CP_STATUS,
        CP_CAUSE,
        CP_EPC,
        CP_PRID,
        CP_CONFIG,
        CP_CONFIG1,
        CP_ERROREPC,
        CP_NONE
    } cprid_t;

    localparam logic [7:0] RS_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] RS_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] RS_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] RS_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] RS_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] RS_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] RS_PRID     = {5'd15, 3'd0};
    localparam logic [7:0] RS_CONFIG   = {5'd16, 3'd0};
    localparam logic [7:0] RS_CONFIG1  = {5'd16, 3'd1};
    localparam logic [7:0] RS_ERROREPC = {5'd30, 3'd0};

    localparam logic [31:0] MASK_ALL    = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_STATUS = 32'h0000_FF03;
    localparam logic [31:0] MASK_CAUSE  = 32'h0000_0300;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [8:0] rsv_hi;
        logic       bev;
        logic [5:0] rsv_mid;
        logic [7:0] im;
        logic [5:0] rsv_lo;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsv_hi;
        logic [7:0]  ip;
        logic        rsv_mid;
        logic [4:0]  exc_code;
        logic [1:0]  rsv_lo;
    } cause_t;

    function automatic cprid_t decode_sel(input logic [7:0] sel);
        decode_sel = CP_NONE;
        case (sel)
            RS_BADVADDR: decode_sel = CP_BADVADDR;
            RS_COUNT:    decode_sel = CP_COUNT;
            RS_COMPARE:  decode_sel = CP_COMPARE;
            RS_STATUS:   decode_sel = CP_STATUS;
            RS_CAUSE:    decode_sel = CP_CAUSE;
            RS_EPC:      decode_sel = CP_EPC;
            RS_PRID:     decode_sel = CP_PRID;
            RS_CONFIG:   decode_sel = CP_CONFIG;
            RS_CONFIG1:  decode_sel = CP_CONFIG1;
            RS_ERROREPC: decode_sel = CP_ERROREPC;
            default:     decode_sel = CP_NONE;
        endcase
    endfunction

    // RO and unimplemented registers get a zero mask, so a write to them is a no-op.
    function automatic logic [31:0] wr_mask(input cprid_t id);
        wr_mask = '0;
        case (id)
            CP_COUNT, CP_COMPARE, CP_EPC, CP_ERROREPC: wr_mask = MASK_ALL;
            CP_STATUS: wr_mask = MASK_STATUS;
            CP_CAUSE:  wr_mask = MASK_CAUSE;
            default:   wr_mask = '0;
        endcase
    endfunction

    function automatic logic [31:0] cp0_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [31:0] mask);
        cp0_merge = (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: Count (half-rate increment), Compare, and the sticky timer-interrupt flag.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);
    logic        r_tick;
    logic        r_ti;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    // The match uses pre-update Count; a Compare write clears TI even on a match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_ti      <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
        end else begin
            r_tick    <= ~r_tick;
            r_count   <= i_count_we ? i_wr_data : r_count + {31'd0, r_tick};
            r_compare <= i_compare_we ? i_wr_data : r_compare;
            r_ti      <= i_compare_we ? 1'b0 : (r_ti | (r_count == r_compare));
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 register file serving MFC0/MTC0, exception entry/ERET, timer and
// external interrupts, and the interrupt request to commit.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE    = 32'h0001_8003,
    parameter logic [31:0] CONFIG_VALUE  = 32'h8000_0000,
    parameter logic [31:0] CONFIG1_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_invalid,
    input  logic        wr_en,
    input  logic [7:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [5:0]  ext_int,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_ds,
    input  logic        exc_badvaddr_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    output logic [31:0] epc,
    output logic        exl,
    output logic        int_req
);
    cprid_t      w_rd_id;
    cprid_t      w_wr_id;
    logic [31:0] w_mask;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    status_t     w_status_nx;
    cause_t      w_cause_nx;
    cause_t      w_cause_rd;
    logic [31:0] w_epc_nx;
    logic [31:0] w_badvaddr_nx;
    status_t     r_status;
    cause_t      r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_errorepc;
    logic [31:0] r_badvaddr;

    assign w_rd_id = decode_sel(rd_sel);
    assign w_wr_id = decode_sel(wr_sel);
    assign w_mask  = wr_mask(w_wr_id);

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (wr_en && w_wr_id == CP_COUNT),
        .i_compare_we (wr_en && w_wr_id == CP_COMPARE),
        .i_wr_data    (wr_data),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Apply MTC0 first, then ERET, then exception entry, so later steps win shared fields.
    always_comb begin
        w_status_nx = (wr_en && w_wr_id == CP_STATUS) ? status_t'(cp0_merge(r_status, wr_data, w_mask)) : r_status;
        w_cause_nx  = (wr_en && w_wr_id == CP_CAUSE) ? cause_t'(cp0_merge(r_cause, wr_data, w_mask)) : r_cause;
        w_epc_nx    = (wr_en && w_wr_id == CP_EPC) ? wr_data : r_epc;
        w_badvaddr_nx = (exc_valid && exc_badvaddr_valid) ? exc_badvaddr : r_badvaddr;
        w_cause_nx.ip[7:2] = {ext_int[5] | w_ti, ext_int[4:0]};
        if (eret) w_status_nx.exl = 1'b0;
        if (exc_valid) begin
            w_cause_nx.exc_code = exc_code;
            w_status_nx.exl = 1'b1;
            if (!r_status.exl) begin
                w_epc_nx = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
                w_cause_nx.bd = exc_in_ds;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status   <= status_t'(STATUS_RESET);
            r_cause    <= '0;
            r_epc      <= '0;
            r_errorepc <= '0;
            r_badvaddr <= '0;
        end else begin
            r_status   <= w_status_nx;
            r_cause    <= w_cause_nx;
            r_epc      <= w_epc_nx;
            r_errorepc <= (wr_en && w_wr_id == CP_ERROREPC) ? wr_data : r_errorepc;
            r_badvaddr <= w_badvaddr_nx;
        end
    end

    always_comb begin
        w_cause_rd    = r_cause;
        w_cause_rd.ti = w_ti;
    end

    always_comb begin
        rd_data    = '0;
        rd_invalid = 1'b0;
        case (w_rd_id)
            CP_BADVADDR: rd_data = r_badvaddr;
            CP_COUNT:    rd_data = w_count;
            CP_COMPARE:  rd_data = w_compare;
            CP_STATUS:   rd_data = r_status;
            CP_CAUSE:    rd_data = w_cause_rd;
            CP_EPC:      rd_data = r_epc;
            CP_PRID:     rd_data = PRID_VALUE;
            CP_CONFIG:   rd_data = CONFIG_VALUE;
            CP_CONFIG1:  rd_data = CONFIG1_VALUE;
            CP_ERROREPC: rd_data = r_errorepc;
            default:     rd_invalid = 1'b1;
        endcase
    end

    assign epc     = r_epc;
    assign exl     = r_status.exl;
    assign int_req = r_status.ie & ~r_status.exl & |(r_cause.ip & r_status.im);
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed CP0 scenarios; expectations queue into a scoreboard that a
// separate monitor drains and compares against the DUT outputs.
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    localparam int K_RD = 0, K_INV = 1, K_IRQ = 2, K_EPC = 3, K_EXL = 4;

    logic        clk = 1'b0, reset = 1'b0;
    logic [7:0]  rd_sel = 8'h0, wr_sel = 8'h0;
    logic [31:0] rd_data, wr_data = 32'h0, exc_pc = 32'h0, exc_badvaddr = 32'h0, epc;
    logic        rd_invalid, wr_en = 1'b0, exc_valid = 1'b0, exc_in_ds = 1'b0;
    logic        exc_badvaddr_valid = 1'b0, eret = 1'b0, exl, int_req;
    logic [5:0]  ext_int = 6'h0;
    logic [4:0]  exc_code = 5'h0;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int n_push = 0, n_pop = 0, errors = 0, checks = 0;

    always #50 clk = ~clk;

    cp0_regfile dut (
        .clk(clk), .reset(reset), .rd_sel(rd_sel), .rd_data(rd_data), .rd_invalid(rd_invalid),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .ext_int(ext_int),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_in_ds(exc_in_ds),
        .exc_badvaddr_valid(exc_badvaddr_valid), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .epc(epc), .exl(exl), .int_req(int_req)
    );

    initial forever begin
        item_t       it;
        logic [31:0] act;
        wait (n_push > n_pop);
        #1;
        it = q.pop_front();
        n_pop++;
        act = it.kind == K_RD ? rd_data : it.kind == K_INV ? {31'd0, rd_invalid} :
              it.kind == K_IRQ ? {31'd0, int_req} : it.kind == K_EPC ? epc : {31'd0, exl};
        checks++;
        if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
    end

    task automatic expect_val(input int kind, input logic [7:0] sel, input logic [31:0] exp, input string name);
        rd_sel = sel;
        q.push_back('{name: name, kind: kind, exp: exp});
        n_push++;
        #2;
    endtask

    task automatic rd(input logic [7:0] sel, input logic [31:0] exp, input string name);
        expect_val(K_RD, sel, exp, name);
    endtask

    task automatic chk(input int kind, input logic [31:0] exp, input string name);
        expect_val(kind, rd_sel, exp, name);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mtc0(input logic [7:0] sel, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                       input logic bv, input logic [31:0] addr);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_in_ds = ds;
        exc_badvaddr_valid = bv; exc_badvaddr = addr;
    endtask

    initial begin
        #5 reset = 1'b1;
        #5;
        rd(RS_STATUS, 32'h0040_0000, "reset_status");
        chk(K_INV, 32'd0, "reset_status_valid");
        rd(RS_CAUSE, 32'h0, "reset_cause");
        rd(RS_COUNT, 32'h0, "reset_count");
        rd(RS_PRID, 32'h0001_8003, "prid");
        chk(K_IRQ, 32'd0, "reset_int_req");
        chk(K_EPC, 32'h0, "reset_epc");
        chk(K_EXL, 32'd0, "reset_exl");
        @(negedge clk);
        reset = 1'b0;
        cyc(10);
        rd(RS_COUNT, 32'd5, "count_after_10");
        wr_en = 1'b1; wr_sel = RS_COUNT; wr_data = 32'hFFFF_FFFF;
        rd(RS_COUNT, 32'd5, "count_no_bypass");
        @(negedge clk);
        wr_en = 1'b0;
        cyc(2);
        rd(RS_COUNT, 32'h0, "count_wrap");
        mtc0(RS_COMPARE, 32'd8);
        mtc0(RS_STATUS, 32'h0000_8001);
        cyc(13);
        rd(RS_COUNT, 32'd8, "count_at_compare");
        rd(RS_CAUSE, 32'h0, "cause_before_match");
        chk(K_IRQ, 32'd0, "irq_before_match");
        cyc(1);
        rd(RS_CAUSE, 32'h4000_0000, "cause_ti_set");
        chk(K_IRQ, 32'd0, "irq_ip_latency");
        cyc(1);
        rd(RS_CAUSE, 32'h4000_8000, "cause_ti_ip7");
        chk(K_IRQ, 32'd1, "irq_timer");
        mtc0(RS_COMPARE, 32'd20);
        rd(RS_CAUSE, 32'h0000_8000, "cause_ti_cleared");
        cyc(1);
        rd(RS_CAUSE, 32'h0, "cause_ip7_cleared");
        chk(K_IRQ, 32'd0, "irq_timer_cleared");
        mtc0(RS_CAUSE, 32'hFFFF_FFFF);
        rd(RS_CAUSE, 32'h0000_0300, "cause_sw_mask");
        chk(K_IRQ, 32'd0, "irq_sw_masked");
        mtc0(RS_CAUSE, 32'h0);
        mtc0(8'h61, 32'hFFFF_FFFF);
        rd(RS_STATUS, 32'h0040_8001, "status_after_bad_sel");
        rd(8'h61, 32'h0, "bad_sel_data");
        chk(K_INV, 32'd1, "bad_sel_invalid");
        mtc0(RS_PRID, 32'h0);
        rd(RS_PRID, 32'h0001_8003, "prid_ro");
        ext_int = 6'b100001;
        cyc(1);
        rd(RS_CAUSE, 32'h0000_8400, "cause_ext_int");
        chk(K_IRQ, 32'd1, "irq_ext_int");
        ext_int = 6'b0;
        mtc0(RS_COMPARE, 32'hFFFF_0000);
        rd(RS_CAUSE, 32'h0, "cause_ext_cleared");
        chk(K_IRQ, 32'd0, "irq_ext_cleared");
        exc(EXC_ADEL, 32'hBFC0_0104, 1'b1, 1'b1, 32'hBFC0_0001);
        @(negedge clk);
        exc_valid = 1'b0;
        chk(K_EPC, 32'hBFC0_0100, "exc_epc");
        chk(K_EXL, 32'd1, "exc_exl");
        rd(RS_CAUSE, 32'h8000_0010, "exc_cause");
        rd(RS_BADVADDR, 32'hBFC0_0001, "exc_badvaddr");
        rd(RS_EPC, 32'hBFC0_0100, "exc_epc_read");
        rd(RS_STATUS, 32'h0040_8003, "exc_status");
        chk(K_IRQ, 32'd0, "exc_irq_masked");
        exc(EXC_ADES, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        exc_valid = 1'b0;
        chk(K_EPC, 32'hBFC0_0100, "nested_epc");
        rd(RS_CAUSE, 32'h8000_0014, "nested_cause");
        rd(RS_BADVADDR, 32'hBFC0_0001, "nested_badvaddr");
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        chk(K_EXL, 32'd0, "eret_exl");
        rd(RS_STATUS, 32'h0040_8001, "eret_status");
        exc(EXC_SYS, 32'h8000_0180, 1'b0, 1'b0, 32'h0);
        eret = 1'b1;
        mtc0(RS_STATUS, 32'h0000_0001);
        exc_valid = 1'b0; eret = 1'b0;
        rd(RS_STATUS, 32'h0040_0003, "prio_status");
        chk(K_EXL, 32'd1, "prio_exl");
        chk(K_EPC, 32'h8000_0180, "prio_epc");
        rd(RS_CAUSE, 32'h0000_0020, "prio_cause");
        mtc0(RS_ERROREPC, 32'h1234_5678);
        rd(RS_ERROREPC, 32'h1234_5678, "errorepc");
        mtc0(RS_EPC, 32'hA000_0000);
        chk(K_EPC, 32'hA000_0000, "epc_mtc0");
        rd(RS_CONFIG, 32'h8000_0000, "config");
        rd(RS_CONFIG1, 32'h0, "config1");
        rd(RS_COMPARE, 32'hFFFF_0000, "compare_read");
        wr_en = 1'b1; wr_sel = RS_COUNT; wr_data = 32'h55;
        #10 reset = 1'b1;
        #1;
        rd(RS_STATUS, 32'h0040_0000, "rst_status");
        rd(RS_CAUSE, 32'h0, "rst_cause");
        rd(RS_COUNT, 32'h0, "rst_count");
        rd(RS_COMPARE, 32'h0, "rst_compare");
        rd(RS_EPC, 32'h0, "rst_epc_read");
        rd(RS_ERROREPC, 32'h0, "rst_errorepc");
        rd(RS_BADVADDR, 32'h0, "rst_badvaddr");
        chk(K_EPC, 32'h0, "rst_epc");
        chk(K_EXL, 32'd0, "rst_exl");
        chk(K_IRQ, 32'd0, "rst_irq");
        @(negedge clk);
        rd(RS_COUNT, 32'h0, "rst_count_held");
        wr_en = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 100 && n_pop != n_push; i++) #1;
        if (n_pop != n_push) begin
            errors++;
            $display("FAIL drain: got %0d expected %0d", n_pop, n_push);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
